move_command_generator: RTL

Producer side of the player-move interface: turns three raw push-buttons (left, right, rotate) into the `move` / `move_valid` / `move_clk` strobe protocol consumed by the game executioner. Provides input synchronisation, debouncing, delayed auto-repeat for horizontal moves and single-shot rotate. Commands are serialised through a one-command-at-a-time issue FSM, so every command is a clean, consumer-visible `move_clk` pulse. Sits in the `clk` domain between the board button pins and the game executioner.

---
 rtl/tetris_pkg.sv | 12 +
 rtl/button_debouncer.sv | 40 ++++
 rtl/move_command_generator.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared types for the player-move interface between the button front end
// and the game executioner.
package tetris_pkg;

    typedef enum logic [1:0] {
        CMD_NONE   = 2'd0,
        CMD_LEFT   = 2'd1,
        CMD_RIGHT  = 2'd2,
        CMD_ROTATE = 2'd3
    } command_t;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a stability counter; the debounced level
// flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/move_command_generator.sv
// Turns left/right/rotate buttons into move/move_valid/move_clk strobes with
// delayed auto-repeat for horizontal moves and one command in flight at a time.
import tetris_pkg::*;

module move_command_generator #(
    parameter int DEBOUNCE_CYCLES    = 20000,
    parameter int DAS_DELAY_CYCLES   = 3000000,
    parameter int ARR_CYCLES         = 1000000,
    parameter int STROBE_HIGH_CYCLES = 4,
    parameter int STROBE_LOW_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rotate,
    input  logic       enable,
    output command_t   move,
    output logic       move_valid,
    output logic       move_clk,
    output logic [7:0] issue_count
);

    localparam int TMAX = (DAS_DELAY_CYCLES > ARR_CYCLES) ? DAS_DELAY_CYCLES : ARR_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int SMAX = (STROBE_HIGH_CYCLES > STROBE_LOW_CYCLES) ? STROBE_HIGH_CYCLES
                                                                    : STROBE_LOW_CYCLES;
    localparam int SW   = $clog2(SMAX + 1);

    typedef enum logic [1:0] {H_IDLE, H_DELAY, H_REPEAT} hstate_t;
    typedef enum logic [1:0] {I_IDLE, I_HIGH, I_LOW} istate_t;

    logic       lvl_l, lvl_r, lvl_rot;
    logic [2:0] lvl_d;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .clk(clk), .reset(reset), .btn(btn_left), .level(lvl_l)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .clk(clk), .reset(reset), .btn(btn_right), .level(lvl_r)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_rotate (
        .clk(clk), .reset(reset), .btn(btn_rotate), .level(lvl_rot)
    );

    logic press_l, press_r, press_rot, rel_l, rel_r, rel_dir;

    assign press_l   = enable & lvl_l   & ~lvl_d[0];
    assign press_r   = enable & lvl_r   & ~lvl_d[1];
    assign press_rot = enable & lvl_rot & ~lvl_d[2];
    assign rel_l     = ~lvl_l & lvl_d[0];
    assign rel_r     = ~lvl_r & lvl_d[1];

    // Horizontal auto-repeat state
    hstate_t       h_state, h_next;
    logic [TW-1:0] timer, timer_next;
    logic          dir_right, dir_next;
    logic          set_horz;

    // Issue state
    istate_t       i_state, i_next;
    logic [SW-1:0] scnt, scnt_next;
    command_t      cmd_q, cmd_next, sel_cmd, move_n;
    logic          pend_rot, pend_horz;
    logic          start, take_rot, take_horz;

    assign rel_dir = dir_right ? rel_r : rel_l;

    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_d     <= '0;
            h_state   <= H_IDLE;
            timer     <= '0;
            dir_right <= 1'b0;
        end else begin
            lvl_d     <= {lvl_rot, lvl_r, lvl_l};
            h_state   <= h_next;
            timer     <= timer_next;
            dir_right <= dir_next;
        end
    end

    // Left is tested before right so a same-cycle double press selects left.
    always_comb begin
        h_next     = h_state;
        timer_next = timer;
        dir_next   = dir_right;
        set_horz   = 1'b0;
        if (!enable) begin
            h_next = H_IDLE;
        end else if (press_l) begin
            dir_next   = 1'b0;
            set_horz   = 1'b1;
            timer_next = TW'(DAS_DELAY_CYCLES);
            h_next     = H_DELAY;
        end else if (press_r) begin
            dir_next   = 1'b1;
            set_horz   = 1'b1;
            timer_next = TW'(DAS_DELAY_CYCLES);
            h_next     = H_DELAY;
        end else if (h_state != H_IDLE) begin
            if (rel_dir) begin
                h_next = H_IDLE;
            end else if (timer == TW'(1)) begin
                set_horz   = 1'b1;
                timer_next = TW'(ARR_CYCLES);
                h_next     = H_REPEAT;
            end else begin
                timer_next = timer - TW'(1);
            end
        end
    end

    assign start     = (i_state == I_IDLE) && enable && (pend_rot || pend_horz);
    assign take_rot  = start & pend_rot;
    assign take_horz = start & ~pend_rot;
    assign sel_cmd   = pend_rot ? CMD_ROTATE : (dir_right ? CMD_RIGHT : CMD_LEFT);

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            pend_rot  <= 1'b0;
            pend_horz <= 1'b0;
        end else begin
            if (take_rot)       pend_rot <= 1'b0;
            else if (press_rot) pend_rot <= 1'b1;
            if (take_horz)      pend_horz <= 1'b0;
            else if (set_horz)  pend_horz <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_state <= I_IDLE;
            scnt    <= '0;
            cmd_q   <= CMD_NONE;
        end else begin
            i_state <= i_next;
            scnt    <= scnt_next;
            cmd_q   <= cmd_next;
        end
    end

    always_comb begin
        i_next    = i_state;
        scnt_next = scnt;
        cmd_next  = cmd_q;
        case (i_state)
            I_IDLE: begin
                if (start) begin
                    i_next    = I_HIGH;
                    scnt_next = '0;
                    cmd_next  = sel_cmd;
                end
            end
            I_HIGH: begin
                if (scnt == SW'(STROBE_HIGH_CYCLES - 1)) begin
                    i_next    = I_LOW;
                    scnt_next = '0;
                end else begin
                    scnt_next = scnt + SW'(1);
                end
            end
            I_LOW: begin
                if (scnt == SW'(STROBE_LOW_CYCLES - 1)) begin
                    i_next    = I_IDLE;
                    scnt_next = '0;
                    cmd_next  = CMD_NONE;
                end else begin
                    scnt_next = scnt + SW'(1);
                end
            end
            default: begin
                i_next    = I_IDLE;
                scnt_next = '0;
                cmd_next  = CMD_NONE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up
    // with the state they describe.
    always_comb begin
        move_n = (i_next == I_HIGH) ? cmd_next : CMD_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            move        <= CMD_NONE;
            move_valid  <= 1'b0;
            move_clk    <= 1'b0;
            issue_count <= '0;
        end else begin
            move        <= move_n;
            move_valid  <= (i_next == I_HIGH);
            move_clk    <= (i_next == I_HIGH);
            issue_count <= issue_count + {7'd0, start};
        end
    end

endmodule
